// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider: 2*WIDTH-bit dividend over WIDTH-bit divisor.
// One quotient bit per cycle, valid/ready handshake on both sides.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH-1:0] r_nx, q_nx;
    logic             last;
    logic             zero_div, ovf;
    logic [WIDTH-1:0] div_hi, div_lo;

    assign div_hi   = dividend[2*WIDTH-1:WIDTH];
    assign div_lo   = dividend[WIDTH-1:0];
    assign zero_div = (divisor == '0);
    assign ovf      = (div_hi >= divisor);

    // R was below D before the shift, so the difference always fits WIDTH bits
    assign sh   = {r_q, q_q[WIDTH-1]};
    assign ge   = (sh >= {1'b0, d_q});
    assign r_nx = ge ? (sh[WIDTH-1:0] - d_q) : sh[WIDTH-1:0];
    assign q_nx = {q_q[WIDTH-2:0], ge};
    assign last = (cnt == CW'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (zero_div || ovf) state_nx = DONE;
                    else                 state_nx = BUSY;
                end
            end
            BUSY: if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= div_lo;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else if (ovf) begin
                            quotient    <= '1;
                            remainder   <= div_lo;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end else begin
                            r_q <= div_hi;
                            q_q <= div_lo;
                            d_q <= divisor;
                            cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    r_q <= r_nx;
                    q_q <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        quotient    <= q_nx;
                        remainder   <= r_nx;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider.
// Expected results come from plain integer division in the bench.
module tb_seq_divider;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int tests = 0;
    int fails = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic ez, output logic eo, output int elat);
        longint unsigned a, b;
        a = longint'(dd);
        b = longint'(dv);
        ez = 1'b0;
        eo = 1'b0;
        if (b == 0) begin
            eq = '1; er = dd[W-1:0]; ez = 1'b1; elat = 0;
        end else if (a / b >= 64'd65536) begin
            eq = '1; er = dd[W-1:0]; eo = 1'b1; elat = 0;
        end else begin
            eq = W'(a / b); er = W'(a % b); elat = W;
        end
    endtask

    task automatic submit(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic wait_done(output int lat, input logic busy_noise);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (busy_noise) begin
                in_valid = 1'b1;
                dividend = 32'($urandom);
                divisor  = 16'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [2*W-1:0] dd,
                          input logic [W-1:0] dv, input logic full);
        logic [W-1:0] eq, er;
        logic ez, eo;
        int elat, lat;
        model(dd, dv, eq, er, ez, eo, elat);
        submit(dd, dv);
        wait_done(lat, 1'b0);
        check({tag, "_q"}, 64'(quotient), 64'(eq));
        check({tag, "_r"}, 64'(remainder), 64'(er));
        if (full) begin
            check({tag, "_lat"}, 64'(lat), 64'(elat));
            check({tag, "_dz"}, 64'(div_by_zero), 64'(ez));
            check({tag, "_ov"}, 64'(overflow), 64'(eo));
            release_out();
        end else begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] a, b, hq, hr, eq, er;
        logic hz, ho, ez, eo;
        logic [2*W-1:0] dd;
        int lat, elat;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 32'd100, 16'd7, 1'b1);
        check("basic_const_q", 64'(quotient), 64'd14);
        run_op("max1", 32'hFFFE_0001, 16'hFFFF, 1'b1);
        run_op("max2", 32'h0000_FFFF, 16'h0001, 1'b1);
        run_op("dz", 32'h1234_5678, 16'h0000, 1'b1);
        run_op("ovf", 32'h0001_0000, 16'h0001, 1'b1);

        // backpressure with noise on the input side while busy
        model(32'd100, 16'd7, eq, er, ez, eo, elat);
        submit(32'd100, 16'd7);
        wait_done(lat, 1'b1);
        check("bp_lat", 64'(lat), 64'(elat));
        hq = quotient; hr = remainder; hz = div_by_zero; ho = overflow;
        check("bp_q", 64'(hq), 64'(eq));
        check("bp_r", 64'(hr), 64'(er));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 32'($urandom);
            divisor  = 16'($urandom);
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold", 64'({quotient, remainder, hz, ho}),
                  64'({eq, er, div_by_zero, overflow}));
        end
        in_valid = 1'b0;
        release_out();
        check("bp_keep_q", 64'(quotient), 64'(eq));

        // asynchronous reset in the middle of an operation
        submit(32'h0006_1A80, 16'h0123);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_outs", 64'({quotient, remainder, div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        run_op("resub", 32'h0006_1A80, 16'h0123, 1'b1);

        // round trip of products
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            dd = 32'(a) * 32'(b);
            submit(dd, b);
            wait_done(lat, 1'b0);
            check("rt_q", 64'(quotient), 64'(a));
            check("rt_r", 64'(remainder), 64'd0);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        // random pairs: invariant on normal results, model on all
        for (int i = 0; i < 200; i++) begin
            b = (i % 10 == 0) ? 16'd0 : 16'($urandom);
            dd = 32'($urandom);
            if (i % 2 == 0 && b != 0)
                dd[2*W-1:W] = 16'($urandom_range(0, int'(b) - 1));
            model(dd, b, eq, er, ez, eo, elat);
            submit(dd, b);
            wait_done(lat, 1'b0);
            check("rnd_q", 64'(quotient), 64'(eq));
            check("rnd_r", 64'(remainder), 64'(er));
            check("rnd_flags", 64'({div_by_zero, overflow}), 64'({ez, eo}));
            check("rnd_lat", 64'(lat), 64'(elat));
            if (!ez && !eo) begin
                check("rnd_inv", 64'(quotient) * 64'(b) + 64'(remainder), 64'(dd));
                check("rnd_rlt", 64'(remainder < b), 64'd1);
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
